// File: rtl/alu_md_pkg.sv
// ============================================================================
// Module      : alu_md_pkg
// Description : Shared operation encodings and FSM state type for alu_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_md_pkg;

  localparam logic [2:0] c_op_mult  = 3'b000;
  localparam logic [2:0] c_op_multu = 3'b001;
  localparam logic [2:0] c_op_div   = 3'b010;
  localparam logic [2:0] c_op_divu  = 3'b011;
  localparam logic [2:0] c_op_mthi  = 3'b100;
  localparam logic [2:0] c_op_mtlo  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage : alu_md_pkg

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
// Module      : alu_muldiv
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers (radix-2 shift-add multiply, restoring divide).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_muldiv
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Two's-complement magnitude; only applied when the operation is signed.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic             sgn);
    f_mag = (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic                 w_signed;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_rem_shift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_signed    = (op == c_op_mult) || (op == c_op_div);
  assign w_sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign w_rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff      = w_rem_shift - {1'b0, b_q};
  assign w_prod      = neg_lo_q ? -acc_q : acc_q;
  assign w_quo       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign w_rem       = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
              acc_d    = {{WIDTH{1'b0}}, f_mag(op_a, w_signed)};
              b_d      = f_mag(op_b, w_signed);
              a_d      = op_a;
              is_div_d = op[1];
              neg_lo_d = w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              neg_hi_d = w_signed && op_a[WIDTH-1];
              zero_d   = (op_b == '0);
              cnt_d    = '0;
              state_d  = ST_CALC;
            end
            c_op_mthi: hi_d = op_a;
            c_op_mtlo: lo_d = op_a;
            default: ;
          endcase
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          if (!w_diff[WIDTH])
            acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {w_rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {w_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = ST_FIN;
      end

      ST_FIN: begin
        if (!is_div_q) begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end else if (zero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = w_rem;
          lo_d = w_quo;
        end
        dbz_d   = is_div_q && zero_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule : alu_muldiv

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
// Module      : tb_alu_muldiv
// Description : Self-checking bench for alu_muldiv against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;
  logic             m_dbz;

  alu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rz = 1'b0;
    p  = '0;
    case (o)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          p  = {a, 32'hFFFF_FFFF};
          rz = 1'b1;
        end else if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit interfere, input string name);
    logic [31:0] eh, el;
    logic        ez;
    int          k;
    bit          seen;
    model(o, a, b, eh, el, ez);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); op_a = $urandom; op_b = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    seen = 0;
    for (k = 1; k <= WIDTH + 8; k++) begin
      if (interfere && k == 5) begin
        start = 1'b1; op = 3'($urandom_range(0, 5));
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1; break;
      end
      checks++;
      if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL %s busy_hold cyc %0d: got busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                 name, k, busy, hi, lo, m_hi, m_lo);
      end
    end
    checks++;
    if (!seen || k != WIDTH + 1) begin
      errors++; $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, k, seen, WIDTH + 1);
    end
    checks++;
    if (busy !== 1'b0 || hi !== eh || lo !== el || div_by_zero !== ez) begin
      errors++;
      $display("FAIL %s result: got busy=%b hi=%h lo=%h dbz=%b expected busy=0 hi=%h lo=%h dbz=%b",
               name, busy, hi, lo, div_by_zero, eh, el, ez);
    end
    m_hi = eh; m_lo = el; m_dbz = ez;
  endtask

  task automatic check_done_drop(input string name);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== m_dbz || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b dbz=%b hi=%h lo=%h expected done=0 busy=0 dbz=%b hi=%h lo=%h",
               name, done, busy, div_by_zero, hi, lo, m_dbz, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = 3'b100; op_a = 32'hDEAD_BEEF; op_b = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero",
               busy, done, div_by_zero, hi, lo);
    end
  endtask

  task automatic test_move();
    op = 3'b100; op_a = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m_hi = 32'h1234_5678;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                         hi, lo, busy, done, m_hi, m_lo);
    end
    op = 3'b101; op_a = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m_lo = 32'hCAFE_F00D;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0",
                         hi, lo, busy, done, m_hi, m_lo);
    end
    check_done_drop("move_idle");
  endtask

  task automatic test_reserved();
    for (int r = 6; r <= 7; r++) begin
      op = 3'(r); op_a = $urandom; op_b = $urandom; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL reserved_%0d: got busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                           r, busy, hi, lo, m_hi, m_lo);
      end
    end
    check_done_drop("reserved");
  endtask

  task automatic test_directed();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max"); check_done_drop("multu_max");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");          check_done_drop("mult_neg");
    run_op(3'd3, 32'd7, 32'd2, 0, "divu_7_2");                  check_done_drop("divu_7_2");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");        check_done_drop("div_neg7_2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");   check_done_drop("div_ovf");
    run_op(3'd2, 32'h0000_1234, 32'd0, 0, "div_zero");          check_done_drop("div_zero");
    check_done_drop("dbz_hold");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd0, 0, "divu_zero");         check_done_drop("divu_zero");
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");  check_done_drop("mult_min");
  endtask

  task automatic test_busy_ignore();
    run_op(3'd1, 32'd1000, 32'd3000, 1, "ignore_mul"); check_done_drop("ignore_mul");
    run_op(3'd2, 32'hFFFF_0000, 32'd7, 1, "ignore_div"); check_done_drop("ignore_div");
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 32'd123456, 32'd654321, 0, "b2b_0");
    run_op(3'd2, 32'hFFFF_FF00, 32'd9, 0, "b2b_1");
    run_op(3'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, "b2b_2");
    check_done_drop("b2b_end");
  endtask

  task automatic test_reset_mid();
    int dones;
    op = 3'd1; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op = 3'd1; op_a = 32'd5; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    dones = 0;
    repeat (WIDTH + 8) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", dones);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 17));
        4: b = -32'($urandom_range(1, 17));
        default: ;
      endcase
      run_op(o, a, b, (i % 4) == 0, "random");
      check_done_drop("random");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    test_reset();
    test_move();
    test_reserved();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_muldiv

`default_nettype wire
